// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, reset PC and bubble encoding for the instruction-fetch stage.
// Also holds the slot-accounting helper shared by the fetch logic and its FIFO.
package if_fetch_unit_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 17;

  localparam logic [PC_W-1:0]    RESET_PC = 16'h0000;
  // LLB R0,#0 -- architecturally a no-op, safe to hand decode when nothing was fetched
  localparam logic [INSTR_W-1:0] BUBBLE   = 17'h00000;

  localparam logic [2:0] FIFO_SLOTS = 3'd2;

  typedef logic [1:0] cnt_t;

  function automatic logic [2:0] slots_used(input cnt_t occupancy, input cnt_t outstanding);
    return {1'b0, occupancy} + {1'b0, outstanding};
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_fifo2.sv
// Two-entry FIFO of {instr, nxt_pc}; head is visible combinationally, one-cycle write-to-head.
// No internal backpressure: the caller never pushes when full; clear wins over push/pop.
module fetch_fifo2
  import if_fetch_unit_pkg::*;
#(
  parameter int IW = 17,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [IW-1:0] push_instr_i,
  input  logic [AW-1:0] push_nxt_pc_i,
  input  logic          pop_i,
  output logic [IW-1:0] head_instr_o,
  output logic [AW-1:0] head_nxt_pc_o,
  output cnt_t          count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [IW-1:0] instr_q  [2];
  logic [AW-1:0] nxt_pc_q [2];
  logic          wr_q;
  logic          rd_q;
  cnt_t          cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q[0]  <= '0;
      instr_q[1]  <= '0;
      nxt_pc_q[0] <= '0;
      nxt_pc_q[1] <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      cnt_q       <= '0;
    end else if (clr_i) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        instr_q[wr_q]  <= push_instr_i;
        nxt_pc_q[wr_q] <= push_nxt_pc_i;
        wr_q           <= ~wr_q;
      end
      if (pop_i) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_instr_o  = instr_q[rd_q];
  assign head_nxt_pc_o = nxt_pc_q[rd_q];
  assign count_o       = cnt_q;
  assign full_o        = (cnt_q == 2'd2);
  assign empty_o       = (cnt_q == 2'd0);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order IM reads, buffers 2 returns, feeds decode.
// Head reaches decode one cycle after return; stall holds the head and throttles issue via slot count.
module if_fetch_unit #(
  parameter int                  PC_W     = if_fetch_unit_pkg::PC_W,
  parameter int                  INSTR_W  = if_fetch_unit_pkg::INSTR_W,
  parameter logic [PC_W-1:0]     RESET_PC = if_fetch_unit_pkg::RESET_PC,
  parameter logic [INSTR_W-1:0]  BUBBLE   = if_fetch_unit_pkg::BUBBLE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_IM_ID,
  input  logic               flow_change_ID_EX,
  input  logic [PC_W-1:0]    tgt_ID_EX,
  input  logic               hlt_ID_EX,
  output logic               im_req,
  output logic [PC_W-1:0]    im_addr,
  input  logic               im_gnt,
  input  logic               im_rvld,
  input  logic [INSTR_W-1:0] im_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_vld,
  output logic [PC_W-1:0]    nxt_pc_IM_ID,
  output logic [PC_W-1:0]    nxt_pc_ID_EX
);

  import if_fetch_unit_pkg::*;

  localparam logic [PC_W-1:0] PC_ONE = 1;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] ret_pc_q, ret_pc_d;
  cnt_t            out_q, out_d;
  cnt_t            drop_q, drop_d;
  logic            halted_q, halted_d;
  logic [PC_W-1:0] nxt_pc_im_id_q, nxt_pc_im_id_d;
  logic [PC_W-1:0] nxt_pc_id_ex_q;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  cnt_t               fifo_cnt;
  logic [INSTR_W-1:0] head_instr;
  logic [PC_W-1:0]    head_nxt_pc;

  logic gnt_fire, ret_fire, ret_keep;

  // Requests only when the answer is guaranteed a FIFO slot, so overflow cannot happen.
  assign im_req   = rst_n & ~halted_q & (slots_used(fifo_cnt, out_q) < FIFO_SLOTS);
  assign im_addr  = pc_q;
  assign gnt_fire = im_req & im_gnt;
  assign ret_fire = im_rvld & (out_q != 2'd0);
  assign ret_keep = ret_fire & (drop_q == 2'd0);

  assign fifo_push = ret_keep & ~flow_change_ID_EX;
  assign fifo_pop  = ~stall_IM_ID & ~fifo_empty & ~flow_change_ID_EX;

  fetch_fifo2 #(
    .IW (INSTR_W),
    .AW (PC_W)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr_i         (flow_change_ID_EX),
    .push_i        (fifo_push),
    .push_instr_i  (im_rdata),
    .push_nxt_pc_i (ret_pc_q + PC_ONE),
    .pop_i         (fifo_pop),
    .head_instr_o  (head_instr),
    .head_nxt_pc_o (head_nxt_pc),
    .count_o       (fifo_cnt),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty)
  );

  always_comb begin
    pc_d           = pc_q;
    ret_pc_d       = ret_pc_q;
    out_d          = out_q;
    drop_d         = drop_q;
    halted_d       = halted_q | hlt_ID_EX;
    nxt_pc_im_id_d = nxt_pc_im_id_q;

    case ({gnt_fire, ret_fire})
      2'b10:   out_d = out_q + 2'd1;
      2'b01:   out_d = out_q - 2'd1;
      default: out_d = out_q;
    endcase

    // ret_pc tracks the address of the next return that will be kept.
    if (flow_change_ID_EX) begin
      pc_d     = tgt_ID_EX;
      ret_pc_d = tgt_ID_EX;
      drop_d   = out_d;
    end else begin
      if (gnt_fire) begin
        pc_d = pc_q + PC_ONE;
      end
      if (ret_keep) begin
        ret_pc_d = ret_pc_q + PC_ONE;
      end
      if (ret_fire && (drop_q != 2'd0)) begin
        drop_d = drop_q - 2'd1;
      end
    end

    if (fifo_pop) begin
      nxt_pc_im_id_d = head_nxt_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q           <= RESET_PC;
      ret_pc_q       <= RESET_PC;
      out_q          <= '0;
      drop_q         <= '0;
      halted_q       <= 1'b0;
      nxt_pc_im_id_q <= RESET_PC + PC_ONE;
      nxt_pc_id_ex_q <= RESET_PC + PC_ONE;
    end else begin
      pc_q           <= pc_d;
      ret_pc_q       <= ret_pc_d;
      out_q          <= out_d;
      drop_q         <= drop_d;
      halted_q       <= halted_d;
      nxt_pc_im_id_q <= nxt_pc_im_id_d;
      nxt_pc_id_ex_q <= nxt_pc_im_id_q;
    end
  end

  assign instr        = fifo_empty ? BUBBLE : head_instr;
  assign instr_vld    = ~fifo_empty;
  assign nxt_pc_IM_ID = nxt_pc_im_id_q;
  assign nxt_pc_ID_EX = nxt_pc_id_ex_q;

  a_rvld_without_request: assert property (@(posedge clk) disable iff (!rst_n)
    im_rvld |-> (out_q != 2'd0));

  a_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_push |-> !fifo_full);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboarded bench for if_fetch_unit: a latency-programmable memory answers requests, stimulus
// queues the expected decode stream, and a monitor compares whatever the fetch unit presents.
module tb_if_fetch_unit;

  localparam logic [16:0] BUBBLE_V = 17'h00000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_IM_ID = 1'b1;
  logic        flow_change_ID_EX = 1'b0;
  logic [15:0] tgt_ID_EX = 16'h0000;
  logic        hlt_ID_EX = 1'b0;
  logic        im_req;
  logic [15:0] im_addr;
  logic        im_gnt = 1'b1;
  logic        im_rvld = 1'b0;
  logic [16:0] im_rdata = 17'h0;
  logic [16:0] instr;
  logic        instr_vld;
  logic [15:0] nxt_pc_IM_ID;
  logic [15:0] nxt_pc_ID_EX;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_IM_ID       (stall_IM_ID),
    .flow_change_ID_EX (flow_change_ID_EX),
    .tgt_ID_EX         (tgt_ID_EX),
    .hlt_ID_EX         (hlt_ID_EX),
    .im_req            (im_req),
    .im_addr           (im_addr),
    .im_gnt            (im_gnt),
    .im_rvld           (im_rvld),
    .im_rdata          (im_rdata),
    .instr             (instr),
    .instr_vld         (instr_vld),
    .nxt_pc_IM_ID      (nxt_pc_IM_ID),
    .nxt_pc_ID_EX      (nxt_pc_ID_EX)
  );

  typedef struct { logic [15:0] addr; int due; } req_t;
  typedef struct { logic [16:0] instr; logic [15:0] nxt; } exp_t;

  req_t        pend[$];
  exp_t        exp_q[$];
  int          cyc = 0;
  int          lat = 1;
  int          gnt_mode = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] model_pc = 16'h0000;
  logic [15:0] stream_pc = 16'h0000;
  bit          halt_chk = 1'b0;

  function automatic logic [16:0] mem_val(input logic [15:0] a);
    return {1'b1, a ^ 16'h5A3C};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, want);
  endtask

  // Memory: in-order returns, each `lat` cycles after its grant.
  always @(negedge clk) begin
    req_t r;
    if (!rst_n) begin
      pend.delete();
      im_rvld = 1'b0;
    end else begin
      cyc++;
      im_rvld = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        r        = pend.pop_front();
        im_rvld  = 1'b1;
        im_rdata = mem_val(r.addr);
      end
      im_gnt = (gnt_mode == 0) || cyc[0];
      if (im_req && im_gnt) begin
        r.addr = im_addr;
        r.due  = cyc + lat;
        pend.push_back(r);
      end
    end
  end

  // Monitor
  bit          c1_vld = 1'b0, c2_vld = 1'b0, hold_vld = 1'b0;
  logic [15:0] c1_val = 16'h0, c2_val = 16'h0;
  logic [16:0] hold_instr = 17'h0;

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n) begin
      if (c2_vld) check("nxt_pc_ID_EX", nxt_pc_ID_EX, c2_val);
      c2_vld = c1_vld;
      c2_val = c1_val;
      if (c1_vld) check("nxt_pc_IM_ID", nxt_pc_IM_ID, c1_val);
      c1_vld = 1'b0;

      if (hold_vld) check("held_instr", instr, hold_instr);
      hold_vld   = instr_vld && stall_IM_ID && !flow_change_ID_EX;
      hold_instr = instr;

      if (!instr_vld) check("bubble", instr, BUBBLE_V);

      if (im_req && im_gnt) begin
        check("im_addr", im_addr, model_pc);
        check("outstanding_le_2", pend.size() <= 2, 1);
        model_pc = model_pc + 16'd1;
      end
      if (flow_change_ID_EX) model_pc = tgt_ID_EX;
      if (halt_chk) check("im_req_halted", im_req, 0);

      if (instr_vld && !stall_IM_ID && !flow_change_ID_EX) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_instr: got %0h, want none", instr);
        end else begin
          e = exp_q.pop_front();
          check("instr", instr, e.instr);
          c1_vld = 1'b1;
          c1_val = e.nxt;
        end
      end
    end
  end

  task automatic do_redirect(input logic [15:0] t);
    flow_change_ID_EX = 1'b1;
    tgt_ID_EX         = t;
    @(negedge clk); #1;
    flow_change_ID_EX = 1'b0;
    stream_pc         = t;
    check("empty_after_redirect", instr_vld, 0);
  endtask

  // Lets decode consume n instructions; then mode 0 stalls, mode 1 redirects with two
  // reads in flight, mode 2 redirects in a cycle with a return and a would-be pop.
  task automatic run(input int n, input int mode, input logic [15:0] t);
    int   pushed = 0;
    int   guard  = 0;
    exp_t e;
    stall_IM_ID = 1'b0;
    forever begin
      if (pushed >= n && exp_q.size() == 0 &&
          (mode == 0 || (mode == 1 && pend.size() == 2) ||
           (mode == 2 && im_rvld && instr_vld))) begin
        if (mode == 0) stall_IM_ID = 1'b1;
        else do_redirect(t);
        break;
      end
      if (exp_q.size() == 0 && instr_vld) begin
        e.instr = mem_val(stream_pc);
        e.nxt   = stream_pc + 16'd1;
        exp_q.push_back(e);
        stream_pc = stream_pc + 16'd1;
        pushed++;
      end
      @(negedge clk); #1;
      guard++;
      if (guard > 300) begin
        n_checks++;
        $display("FAIL run_timeout: got %0d consumed, want %0d", pushed, n);
        stall_IM_ID = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_instr", instr, BUBBLE_V);
    check("rst_instr_vld", instr_vld, 0);
    check("rst_im_req", im_req, 0);
    check("rst_nxt_pc_IM_ID", nxt_pc_IM_ID, 16'h0001);
    check("rst_nxt_pc_ID_EX", nxt_pc_ID_EX, 16'h0001);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("startup_instr_vld", instr_vld, (k == 2) ? 1 : 0);
    end

    run(5, 0, 16'h0);
    repeat (4) begin @(negedge clk); #1; end
    check("stall_full_no_req", im_req, 0);
    check("stall_instr_vld", instr_vld, 1);
    check("stall_head_addr5", instr, mem_val(16'h0005));
    run(6, 0, 16'h0);

    lat = 3;
    gnt_mode = 1;
    run(6, 0, 16'h0);
    run(2, 1, 16'h0040);

    lat = 1;
    gnt_mode = 0;
    run(3, 2, 16'h0080);
    run(3, 0, 16'h0);

    do_redirect(16'hFFFE);
    run(4, 0, 16'h0);

    lat = 3;
    do_redirect(16'h000E);
    for (int g = 0; g < 50 && model_pc != 16'h0010; g++) begin
      @(negedge clk); #1;
    end
    check("halt_pc_reached", model_pc, 16'h0010);
    hlt_ID_EX = 1'b1;
    @(negedge clk); #1;
    hlt_ID_EX = 1'b0;
    halt_chk  = 1'b1;
    run(2, 0, 16'h0);
    stall_IM_ID = 1'b0;
    repeat (20) begin @(negedge clk); #1; end
    check("halted_drained", instr_vld, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1);
  end

endmodule
